fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: imem_stall  in  1  instruction memory busy this cycle (multicycle fetch in flight).
REQ-004 SHALL have port: imem_done  in  1  instruction memory fetch complete, data valid this cycle.
REQ-005 SHALL have port: dmem_stall  in  1  data memory busy; freezes whole front end.
REQ-006 SHALL have port: br_taken  in  1  EX stage resolved a taken branch/jump (redirect).
REQ-007 SHALL have port: ex_mem_read, ex_reg_write  in  1 each  EX instruction is a load / writes a register.
REQ-008 SHALL have port: ex_rd, id_rs, id_rt  in  3 each  register specifiers.
REQ-009 SHALL have port: id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-010 SHALL have port: id_halt  in  1  HALT decoded in ID.
REQ-011 SHALL have port: pc_we  out  1  PC register write enable.
REQ-012 SHALL have port: ifid_stall_n  out  1  IF/ID write enable, active low stall.
REQ-013 SHALL have port: take_new_PC  out  1  squash IF/ID contents into NOP.
REQ-014 SHALL have port: idex_bubble  out  1  insert NOP into ID/EX.
REQ-015 SHALL have port: halted  out  1  core stopped.
REQ-016 SHALL have port: stall_cnt  out  16  saturating count of frozen-PC cycles.
REQ-017 SHALL have port: err  out  1  high when any input is X/Z or state is illegal.

Function
REQ-018 SHALL implement FSM states RUN, IMEM_WAIT, HALTED (2-bit encoding; unused code -> err=1, next state RUN).
REQ-019 SHALL define load_use = ex_mem_read & ex_reg_write & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)), combinational.
REQ-020 SHALL apply priority per cycle: dmem_stall > br_taken > load_use > imem wait.
REQ-021 RUN, dmem_stall=1: pc_we=0, ifid_stall_n=0, idex_bubble=0, take_new_PC=0; state held.
REQ-022 RUN, br_taken=1: pc_we=1, ifid_stall_n=1, take_new_PC=1, idex_bubble=1 (one cycle, same cycle).
REQ-023 RUN, load_use=1: pc_we=0, ifid_stall_n=0, idex_bubble=1 for exactly the cycle load_use is high.
REQ-024 RUN, imem_stall=1 and no higher event: pc_we=0, ifid_stall_n=0, idex_bubble=1; next state IMEM_WAIT.
REQ-025 IMEM_WAIT: pc_we=0, ifid_stall_n=0, idex_bubble=1 until imem_done=1; on imem_done release for that cycle and return to RUN.
REQ-026 br_taken during IMEM_WAIT SHALL set a redir_pend flag; on imem_done with redir_pend=1, take_new_PC=1 that cycle, flag cleared.
REQ-027 br_taken with redir_pend already set SHALL keep flag set (newest redirect wins, PC owned by datapath).
REQ-028 id_halt=1 with take_new_PC=0 and no stall SHALL move to HALTED next cycle; halt squashed by redirect SHALL be ignored.
REQ-029 HALTED: pc_we=0, ifid_stall_n=0, idex_bubble=1, halted=1; exits only on reset.
REQ-030 stall_cnt SHALL increment each cycle pc_we=0 and state!=HALTED, saturating at 16'hFFFF, no wrap.
REQ-031 All outputs except state-derived halted SHALL be combinational from state and current inputs (zero-cycle latency).

Reset
REQ-032 rst_n=0 SHALL immediately force state=RUN, redir_pend=0, stall_cnt=0, halted=0, err=0.
REQ-033 During reset pc_we=0, ifid_stall_n=0, take_new_PC=0, idex_bubble=1; reset mid-IMEM_WAIT discards pending redirect.
REQ-034 First rising edge after rst_n deassertion SHALL operate in RUN.

Structure
REQ-035 State encoding and register-specifier width (3) SHALL live in shared package fetch_pkg.
REQ-036 Load-use comparator SHALL be sub-module hazard_detect; stall_cnt uses existing register module.

Verification
REQ-037 Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_use_rs=1 for 1 cycle -> pc_we=0, idex_bubble=1 one cycle, stall_cnt=1.
REQ-038 Imem miss: imem_stall 4 cycles then imem_done -> IMEM_WAIT 4 cycles, release on done, stall_cnt=5.
REQ-039 Redirect in miss: br_taken at wait cycle 2, imem_done at cycle 4 -> take_new_PC=1 only on done cycle.
REQ-040 Priority: dmem_stall=1, br_taken=1 same cycle -> pc_we=0, take_new_PC=0; br_taken next cycle -> flush.
REQ-041 Halt: id_halt=1 in RUN -> halted=1 next cycle, pc_we=0 forever; id_halt with br_taken -> stays RUN.
REQ-042 Reset mid-wait: rst_n low in IMEM_WAIT with redir_pend=1 -> RUN, stall_cnt=0, no flush after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and widths for the fetch controller
package fetch_pkg;
   localparam int REG_W = 3;
   localparam int CNT_W = 16;
   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_IMEM_WAIT = 2'd1,
      S_HALTED    = 2'd2
   } state_e;
endpackage

// File: rtl/fetch_reg.sv
// fetch_reg: enabled register with asynchronous active-low clear
// Ports: clk, rst_n, en (load enable), d (next value), q (stored value)
module fetch_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/hazard_detect.sv
// hazard_detect: load-use comparator between the EX load and the ID source registers
// Ports: EX load/write flags and rd, ID rs/rt with use flags; load_use out
module hazard_detect
   import fetch_pkg::*;
(
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   output logic             load_use
);
   assign load_use = ex_mem_read & ex_reg_write &
                     ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end stall/flush/halt controller for the pipeline PC and IF/ID, ID/EX registers
// Ports: clk, rst_n; memory stalls (imem_stall, imem_done, dmem_stall); br_taken redirect;
// hazard inputs (ex_*, id_*); id_halt; outputs pc_we, ifid_stall_n, take_new_PC, idex_bubble,
// halted, stall_cnt (saturating frozen-PC cycles), err (unknown input or illegal state)
module fetch_ctrl
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_stall,
   input  logic             imem_done,
   input  logic             dmem_stall,
   input  logic             br_taken,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_halt,
   output logic             pc_we,
   output logic             ifid_stall_n,
   output logic             take_new_PC,
   output logic             idex_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err
);
   state_e state_q, state_d;
   logic   redir_q, redir_d;
   logic   load_use;
   logic   bad_state;

   hazard_detect u_hazard (
      .ex_mem_read (ex_mem_read),
      .ex_reg_write(ex_reg_write),
      .ex_rd       (ex_rd),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .load_use    (load_use)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_RUN;
         redir_q <= 1'b0;
      end else begin
         state_q <= state_d;
         redir_q <= redir_d;
      end

   // Defaults are the frozen/bubbling front end, which is also the in-reset output set.
   always_comb begin
      state_d      = state_q;
      redir_d      = redir_q;
      pc_we        = 1'b0;
      ifid_stall_n = 1'b0;
      take_new_PC  = 1'b0;
      idex_bubble  = 1'b1;
      if (rst_n)
         case (state_q)
            S_RUN:
               if (dmem_stall) idex_bubble = 1'b0;
               else if (br_taken) begin
                  pc_we        = 1'b1;
                  ifid_stall_n = 1'b1;
                  take_new_PC  = 1'b1;
               end else if (!load_use) begin
                  if (imem_stall) state_d = S_IMEM_WAIT;
                  else begin
                     pc_we        = 1'b1;
                     ifid_stall_n = 1'b1;
                     idex_bubble  = 1'b0;
                     state_d      = id_halt ? S_HALTED : S_RUN;
                  end
               end
            S_IMEM_WAIT:
               if (dmem_stall) idex_bubble = 1'b0;
               else if (imem_done) begin
                  // A redirect seen during the miss (or arriving now) flushes the fetched word.
                  pc_we        = 1'b1;
                  ifid_stall_n = 1'b1;
                  take_new_PC  = redir_q | br_taken;
                  idex_bubble  = redir_q | br_taken;
                  redir_d      = 1'b0;
                  state_d      = S_RUN;
               end else redir_d = redir_q | br_taken;
            S_HALTED: begin
            end
            default: state_d = S_RUN;
         endcase
   end

   assign bad_state = (state_q != S_RUN) && (state_q != S_IMEM_WAIT) && (state_q != S_HALTED);
   assign halted    = (state_q == S_HALTED);
   assign err       = rst_n & (bad_state | $isunknown({imem_stall, imem_done, dmem_stall, br_taken,
                               ex_mem_read, ex_reg_write, ex_rd, id_rs, id_rt,
                               id_use_rs, id_use_rt, id_halt}));

   fetch_reg #(.W(CNT_W)) u_stall_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (!pc_we && (state_q != S_HALTED) && (stall_cnt != {CNT_W{1'b1}})),
      .d    (stall_cnt + 16'd1),
      .q    (stall_cnt)
   );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl stall, flush, halt, reset and saturation behaviour
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_stall = 1'b0, imem_done = 1'b0, dmem_stall = 1'b0, br_taken = 1'b0;
   logic        ex_mem_read = 1'b0, ex_reg_write = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic        id_halt = 1'b0;
   logic [2:0]  ex_rd = 3'd3, id_rs = 3'd1, id_rt = 3'd2;
   logic        pc_we, ifid_stall_n, take_new_PC, idex_bubble, halted, err;
   logic [15:0] stall_cnt;

   typedef struct packed {
      logic       rstn, dmem, br, ims, imd, halt;
      logic [2:0] lu;
   } stim_t;
   typedef struct packed {
      logic        pc_we, ifid, take, bub, halt, err;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_stall  (imem_stall),
      .imem_done   (imem_done),
      .dmem_stall  (dmem_stall),
      .br_taken    (br_taken),
      .ex_mem_read (ex_mem_read),
      .ex_reg_write(ex_reg_write),
      .ex_rd       (ex_rd),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_halt     (id_halt),
      .pc_we       (pc_we),
      .ifid_stall_n(ifid_stall_n),
      .take_new_PC (take_new_PC),
      .idex_bubble (idex_bubble),
      .halted      (halted),
      .stall_cnt   (stall_cnt),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic stim_t S(input logic rstn, dmem, br, ims, imd, halt, input logic [2:0] lu);
      return '{rstn, dmem, br, ims, imd, halt, lu};
   endfunction

   function automatic exp_t E(input logic pc, ifid, take, bub, h, input logic [15:0] cnt);
      return '{pc, ifid, take, bub, h, 1'b0, cnt};
   endfunction

   function automatic exp_t observed();
      return '{pc_we, ifid_stall_n, take_new_PC, idex_bubble, halted, err, stall_cnt};
   endfunction

   // lu codes: 0 none, 1 rs hazard, 2 rt hazard, 3 rs match but unused,
   // 4 load without reg write, 5 rs match on a non-load
   task automatic apply(input stim_t s, input exp_t e);
      @(negedge clk);
      rst_n        = s.rstn;
      dmem_stall   = s.dmem;
      br_taken     = s.br;
      imem_stall   = s.ims;
      imem_done    = s.imd;
      id_halt      = s.halt;
      ex_rd        = 3'd3;
      id_rs        = (s.lu == 3'd1 || s.lu >= 3'd3) ? 3'd3 : 3'd1;
      id_rt        = (s.lu == 3'd2) ? 3'd3 : 3'd2;
      ex_mem_read  = (s.lu != 3'd0) && (s.lu != 3'd5);
      ex_reg_write = (s.lu != 3'd0) && (s.lu != 3'd4);
      id_use_rs    = (s.lu != 3'd0) && (s.lu != 3'd3);
      id_use_rt    = (s.lu == 3'd2);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      apply(S(0, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 1, 0, 0));
      void'(exp_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      stim_t st[3];
      exp_t  ex[3];
      exp_t  got, want;
      st = '{S(0, 0, 1, 1, 0, 0, 0), S(0, 0, 0, 0, 0, 1, 1), S(1, 0, 0, 0, 0, 0, 0)};
      ex = '{E(0, 0, 0, 1, 0, 0), E(0, 0, 0, 1, 0, 0), E(1, 1, 0, 0, 0, 0)};
      for (int i = 0; i < 3; i++) begin
         apply(st[i], ex[i]);
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL reset[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t st[8];
      exp_t  ex[8];
      exp_t  got, want;
      do_reset();
      st = '{S(1, 0, 0, 0, 0, 0, 0), S(1, 0, 0, 0, 0, 0, 1), S(1, 0, 0, 0, 0, 0, 0),
             S(1, 0, 0, 0, 0, 0, 2), S(1, 0, 0, 0, 0, 0, 3), S(1, 0, 0, 0, 0, 0, 4),
             S(1, 0, 0, 0, 0, 0, 5), S(1, 0, 0, 0, 0, 0, 0)};
      ex = '{E(1, 1, 0, 0, 0, 0), E(0, 0, 0, 1, 0, 0), E(1, 1, 0, 0, 0, 1),
             E(0, 0, 0, 1, 0, 1), E(1, 1, 0, 0, 0, 2), E(1, 1, 0, 0, 0, 2),
             E(1, 1, 0, 0, 0, 2), E(1, 1, 0, 0, 0, 2)};
      for (int i = 0; i < 8; i++) begin
         apply(st[i], ex[i]);
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL load_use[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_imem_miss();
      stim_t st[7];
      exp_t  ex[7];
      exp_t  got, want;
      do_reset();
      st = '{S(1, 0, 0, 1, 0, 0, 0), S(1, 0, 0, 1, 0, 0, 0), S(1, 0, 0, 1, 0, 0, 0),
             S(1, 0, 0, 1, 0, 0, 0), S(1, 0, 0, 1, 0, 0, 0), S(1, 0, 0, 0, 1, 0, 0),
             S(1, 0, 0, 0, 0, 0, 0)};
      ex = '{E(0, 0, 0, 1, 0, 0), E(0, 0, 0, 1, 0, 1), E(0, 0, 0, 1, 0, 2),
             E(0, 0, 0, 1, 0, 3), E(0, 0, 0, 1, 0, 4), E(1, 1, 0, 0, 0, 5),
             E(1, 1, 0, 0, 0, 5)};
      for (int i = 0; i < 7; i++) begin
         apply(st[i], ex[i]);
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL imem_miss[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_redirect_in_miss();
      stim_t st[6];
      exp_t  ex[6];
      exp_t  got, want;
      do_reset();
      st = '{S(1, 0, 0, 1, 0, 0, 0), S(1, 0, 0, 1, 0, 0, 0), S(1, 0, 1, 1, 0, 0, 0),
             S(1, 0, 1, 1, 0, 0, 0), S(1, 0, 0, 0, 1, 0, 0), S(1, 0, 0, 0, 0, 0, 0)};
      ex = '{E(0, 0, 0, 1, 0, 0), E(0, 0, 0, 1, 0, 1), E(0, 0, 0, 1, 0, 2),
             E(0, 0, 0, 1, 0, 3), E(1, 1, 1, 1, 0, 4), E(1, 1, 0, 0, 0, 4)};
      for (int i = 0; i < 6; i++) begin
         apply(st[i], ex[i]);
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL redirect_in_miss[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_priority();
      stim_t st[9];
      exp_t  ex[9];
      exp_t  got, want;
      do_reset();
      st = '{S(1, 1, 1, 0, 0, 0, 0), S(1, 0, 1, 0, 0, 0, 0), S(1, 1, 0, 0, 0, 0, 1),
             S(1, 0, 1, 0, 0, 0, 1), S(1, 0, 0, 1, 0, 0, 1), S(1, 0, 0, 0, 0, 0, 0),
             S(1, 1, 0, 1, 0, 0, 0), S(1, 0, 1, 0, 0, 0, 0), S(1, 0, 0, 0, 0, 0, 0)};
      ex = '{E(0, 0, 0, 0, 0, 0), E(1, 1, 1, 1, 0, 1), E(0, 0, 0, 0, 0, 1),
             E(1, 1, 1, 1, 0, 2), E(0, 0, 0, 1, 0, 2), E(1, 1, 0, 0, 0, 3),
             E(0, 0, 0, 0, 0, 3), E(1, 1, 1, 1, 0, 4), E(1, 1, 0, 0, 0, 4)};
      for (int i = 0; i < 9; i++) begin
         apply(st[i], ex[i]);
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL priority[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_halt();
      stim_t st[7];
      exp_t  ex[7];
      exp_t  got, want;
      do_reset();
      st = '{S(1, 0, 1, 0, 0, 1, 0), S(1, 0, 0, 0, 0, 0, 0), S(1, 0, 0, 0, 0, 1, 1),
             S(1, 0, 0, 0, 0, 1, 0), S(1, 0, 0, 0, 0, 0, 0), S(1, 0, 1, 1, 0, 0, 0),
             S(1, 0, 0, 0, 0, 0, 0)};
      ex = '{E(1, 1, 1, 1, 0, 0), E(1, 1, 0, 0, 0, 0), E(0, 0, 0, 1, 0, 0),
             E(1, 1, 0, 0, 0, 1), E(0, 0, 0, 1, 1, 1), E(0, 0, 0, 1, 1, 1),
             E(0, 0, 0, 1, 1, 1)};
      for (int i = 0; i < 7; i++) begin
         apply(st[i], ex[i]);
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL halt[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      stim_t st[6];
      exp_t  ex[6];
      exp_t  got, want;
      do_reset();
      st = '{S(1, 0, 0, 1, 0, 0, 0), S(1, 0, 1, 1, 0, 0, 0), S(1, 0, 0, 1, 0, 0, 0),
             S(0, 0, 0, 1, 0, 0, 0), S(1, 0, 0, 0, 1, 0, 0), S(1, 0, 0, 0, 0, 0, 0)};
      ex = '{E(0, 0, 0, 1, 0, 0), E(0, 0, 0, 1, 0, 1), E(0, 0, 0, 1, 0, 2),
             E(0, 0, 0, 1, 0, 0), E(1, 1, 0, 0, 0, 0), E(1, 1, 0, 0, 0, 0)};
      for (int i = 0; i < 6; i++) begin
         apply(st[i], ex[i]);
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL reset_mid_wait[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_saturation();
      exp_t got, want;
      do_reset();
      @(negedge clk);
      dmem_stall = 1'b1;
      repeat (65535) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         apply(S(1, i < 2, 0, 0, 0, 0, 0), E(i == 2, i == 2, 0, 0, 0, 16'hFFFF));
         #2;
         got  = observed();
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL saturation[%0d] got %h want %h", i, got, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_imem_miss();
      test_redirect_in_miss();
      test_priority();
      test_halt();
      test_reset_mid_wait();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
